// File: rtl/sram_be_clr.sv
// sram_be_clr: parametrised single-port SRAM with per-byte write enables,
// a registered read with a valid strobe, and a zero-fill clear sequencer
// that runs after every reset and raises ready when it finishes.

// One byte lane of the array. Writes are synchronous. The read is a plain
// combinational lookup that feeds the top-level rd register.
module sram_be_clr_lane #(
  parameter int DEPTH  = 16384,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdat,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdat
);

  logic [7:0] mem [DEPTH];

  // Byte write. The memory has no reset; the clear sequencer zero-fills it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
  end

  assign rdat = mem[raddr];

endmodule

module sram_be_clr #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16384,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BE_W   = WIDTH / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wd,
  input  logic [BE_W-1:0]   be,
  output logic [WIDTH-1:0]  rd,
  output logic              rvalid,
  output logic              ready
);

  if (WIDTH % 8 != 0) begin : g_width_chk
    $error("sram_be_clr: WIDTH must be a multiple of 8");
  end

  // DEPTH is held one bit wider so the range check also works when DEPTH is
  // an exact power of two.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  typedef struct packed {
    logic                       req;
    logic                       we;
    logic [ADDR_W-1:0]          addr;
    logic [BE_W-1:0][7:0]       wd;
    logic [BE_W-1:0]            be;
  } acc_t;

  state_t               state;
  logic [ADDR_W-1:0]    clr_cnt;
  acc_t                 acc;
  logic                 in_range;
  logic                 acc_ok;
  logic                 wr_go;
  logic                 rd_go;
  logic                 clr_go;
  logic [BE_W-1:0]      lane_we;
  logic [ADDR_W-1:0]    lane_waddr;
  logic [BE_W-1:0][7:0] lane_wdat;
  logic [BE_W-1:0][7:0] rd_word;

  assign acc = '{req: req, we: we, addr: addr, wd: wd, be: be};

  // Only reachable when DEPTH is not a power of two.
  assign in_range = {1'b0, acc.addr} < DEPTH_X;

  // Requests are honoured only once the array is clean. While reset is high
  // nothing is written, so a reset landing mid-clear leaves memory as-is
  // until the restarted sweep reaches it.
  assign acc_ok = (state == IDLE) && acc.req;
  assign wr_go  = !reset && acc_ok && acc.we && in_range;
  assign rd_go  = acc_ok && !acc.we;
  assign clr_go = !reset && (state == CLEAR);

  // Clear shares the write port with the core; the two never overlap
  // because core accesses wait for IDLE.
  assign lane_waddr = clr_go ? clr_cnt : acc.addr;

  for (genvar i = 0; i < BE_W; i++) begin : g_lane
    assign lane_we[i]   = clr_go | (wr_go & acc.be[i]);
    assign lane_wdat[i] = clr_go ? 8'h00 : acc.wd[i];

    sram_be_clr_lane #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_lane (
      .clk   (clk),
      .we    (lane_we[i]),
      .waddr (lane_waddr),
      .wdat  (lane_wdat[i]),
      .raddr (acc.addr),
      .rdat  (rd_word[i])
    );
  end

  // Control FSM: clear sweep after reset, then one access per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready   <= 1'b0;
      rvalid  <= 1'b0;
      rd      <= '0;
    end else begin
      case (state)
        CLEAR: begin
          rvalid  <= 1'b0;
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == CLR_LAST) begin
            state   <= IDLE;
            ready   <= 1'b1;
            clr_cnt <= '0;
          end
        end
        IDLE: begin
          rvalid <= rd_go;
          if (rd_go) rd <= in_range ? rd_word : '0;
        end
        default: begin
          state   <= CLEAR;
          clr_cnt <= '0;
          ready   <= 1'b0;
          rvalid  <= 1'b0;
        end
      endcase
    end
  end

endmodule
